// File: rtl/shift_seq_pkg.sv
// Shared constants, state encoding and helpers for the shift sequencer.
package shift_seq_pkg;

    localparam logic [1:0] SC_NONE = 2'b00;
    localparam logic [1:0] SC_SHL  = 2'b01;
    localparam logic [1:0] SC_SHR  = 2'b10;
    localparam logic [1:0] SC_ROR  = 2'b11;

    localparam int unsigned PASS_MAX_DEF = 7;
    localparam int unsigned AMT_W        = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Amount issued on one datapath pass: the remainder clipped to the pass limit.
    function automatic logic [2:0] pass_amt(input logic [AMT_W-1:0] rem,
                                            input logic [AMT_W-1:0] pmax);
        return (rem > pmax) ? pmax[2:0] : rem[2:0];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer flips to the non-granted side on advance.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       clear_n_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    logic ptr_q;

    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!clear_n_i) begin
            ptr_q <= 1'b0;
        end else if (advance_i) begin
            ptr_q <= grant_o[0];
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Arbitrates two shift requesters and splits each job into barrel-datapath passes.
// Build option SHIFT_SEQ_BYPASS_EN: null jobs (amt==0 or sc==00) skip the datapath.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PASS_MAX = PASS_MAX_DEF,
    parameter int unsigned BR_LAT   = 1
) (
    input  logic               clk_i,
    input  logic               clear_n_i,
    input  logic [1:0]         req_valid_i,
    output logic [1:0]         req_ready_o,
    input  logic [2*WIDTH-1:0] req_data_i,
    input  logic [3:0]         req_sc_i,
    input  logic [9:0]         req_amt_i,
    output logic               br_load_o,
    output logic [WIDTH-1:0]   br_data_o,
    output logic [1:0]         br_sc_o,
    output logic [2:0]         br_amt_o,
    input  logic [WIDTH-1:0]   br_r_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic               rsp_id_o,
    output logic [WIDTH-1:0]   rsp_data_o
);

    localparam int unsigned      WCW       = (BR_LAT > 1) ? $clog2(BR_LAT) : 1;
    localparam logic [AMT_W-1:0] PMAX      = AMT_W'(PASS_MAX);
    localparam logic [WCW-1:0]   WAIT_LAST = WCW'(BR_LAT - 1);

    state_e           state_q;
    logic [1:0]       sc_q;
    logic [AMT_W-1:0] rem_q;
    logic             id_q;
    logic [WCW-1:0]   wcnt_q;

    logic             br_load_q;
    logic [WIDTH-1:0] br_data_q;
    logic [1:0]       br_sc_q;
    logic [2:0]       br_amt_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;

    logic [1:0]       grant;
    logic             accept;
    logic             sel;
    logic [WIDTH-1:0] sel_data;
    logic [1:0]       sel_sc;
    logic [AMT_W-1:0] sel_amt;
    logic [AMT_W-1:0] sel_rem;
    logic [2:0]       first_amt;
    logic [2:0]       next_amt;
    logic             bypass;

    rr_arb2 u_arb (
        .clk_i     (clk_i),
        .clear_n_i (clear_n_i),
        .req_i     (req_valid_i),
        .advance_i (accept),
        .grant_o   (grant)
    );

    // Ready is masked by the reset input so nothing is granted while clear_n is held low.
    assign req_ready_o = (clear_n_i && (state_q == S_IDLE)) ? grant : 2'b00;
    assign accept      = |(req_valid_i & req_ready_o);

    always_comb begin
        sel       = grant[1];
        sel_data  = sel ? req_data_i[2*WIDTH-1:WIDTH] : req_data_i[WIDTH-1:0];
        sel_sc    = sel ? req_sc_i[3:2] : req_sc_i[1:0];
        sel_amt   = sel ? req_amt_i[9:5] : req_amt_i[4:0];
        // A no-shift job still makes one pass, issued with amount 0.
        sel_rem   = (sel_sc == SC_NONE) ? '0 : sel_amt;
        first_amt = pass_amt(sel_rem, PMAX);
        next_amt  = pass_amt(rem_q, PMAX);
    end

`ifdef SHIFT_SEQ_BYPASS_EN
    assign bypass = (sel_sc == SC_NONE) || (sel_amt == '0);
`else
    assign bypass = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!clear_n_i) begin
            state_q     <= S_IDLE;
            sc_q        <= '0;
            rem_q       <= '0;
            id_q        <= 1'b0;
            wcnt_q      <= '0;
            br_load_q   <= 1'b0;
            br_data_q   <= '0;
            br_sc_q     <= '0;
            br_amt_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            br_load_q <= 1'b0;
            br_data_q <= '0;
            br_sc_q   <= '0;
            br_amt_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        sc_q <= sel_sc;
                        id_q <= sel;
                        if (bypass) begin
                            state_q     <= S_DONE;
                            rem_q       <= '0;
                            rsp_valid_q <= 1'b1;
                            rsp_id_q    <= sel;
                            rsp_data_q  <= sel_data;
                        end else begin
                            state_q   <= S_ISSUE;
                            br_load_q <= 1'b1;
                            br_data_q <= sel_data;
                            br_sc_q   <= sel_sc;
                            br_amt_q  <= first_amt;
                            rem_q     <= sel_rem - AMT_W'(first_amt);
                        end
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                    wcnt_q  <= '0;
                end
                S_WAIT: begin
                    if (wcnt_q == WAIT_LAST) begin
                        // The datapath result becomes the next load value or the response.
                        if (rem_q != '0) begin
                            state_q   <= S_ISSUE;
                            br_load_q <= 1'b1;
                            br_data_q <= br_r_i;
                            br_sc_q   <= sc_q;
                            br_amt_q  <= next_amt;
                            rem_q     <= rem_q - AMT_W'(next_amt);
                        end else begin
                            state_q     <= S_DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_id_q    <= id_q;
                            rsp_data_q  <= br_r_i;
                        end
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (rsp_ready_i) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_id_q    <= 1'b0;
                        rsp_data_q  <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign br_load_o   = br_load_q;
    assign br_data_o   = br_data_q;
    assign br_sc_o     = br_sc_q;
    assign br_amt_o    = br_amt_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer with a behavioural barrel datapath model.
module tb_shift_sequencer;
    import shift_seq_pkg::*;

    localparam int W      = 8;
    localparam int PM     = 7;
    localparam int BR_LAT = 1;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] sc;
        logic [4:0] amt;
    } job_t;

    typedef struct {
        logic       id;
        logic [7:0] res;
        logic [7:0] opnd;
        logic [1:0] sc;
        int         passes;
        int         lat;
        int         acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clear_n;
    logic       va, vb;
    logic [7:0] da, db;
    logic [1:0] sa, sbc;
    logic [4:0] aa, ab;
    logic       rsp_ready;

    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [15:0]  req_data;
    logic [3:0]   req_sc;
    logic [9:0]   req_amt;
    logic         br_load;
    logic [7:0]   br_data;
    logic [1:0]   br_sc;
    logic [2:0]   br_amt;
    logic [7:0]   br_r;
    logic         rsp_valid;
    logic         rsp_id;
    logic [7:0]   rsp_data;

    assign req_valid = {vb, va};
    assign req_data  = {db, da};
    assign req_sc    = {sbc, sa};
    assign req_amt   = {ab, aa};

    shift_sequencer #(
        .WIDTH    (W),
        .PASS_MAX (PM),
        .BR_LAT   (BR_LAT)
    ) dut (
        .clk_i       (clk),
        .clear_n_i   (clear_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_data_i  (req_data),
        .req_sc_i    (req_sc),
        .req_amt_i   (req_amt),
        .br_load_o   (br_load),
        .br_data_o   (br_data),
        .br_sc_o     (br_sc),
        .br_amt_o    (br_amt),
        .br_r_i      (br_r),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_data_o  (rsp_data)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic [1:0] hs_seen = 2'b00;
    int   exp_ptr = 0;
    int   cur_rem = 0;
    int   pass_cnt = 0;
    int   first_cyc = -1;
    int   ready_mode = 0;
    bit   gaps = 1'b0;
    job_t qa[$];
    job_t qb[$];
    exp_t sbq[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole-job result computed from the total amount in one step.
    function automatic logic [7:0] ref_result(input logic [7:0] d, input logic [1:0] sc,
                                              input int amt);
        logic [15:0] dd;
        dd = {d, d} >> (amt % 8);
        case (sc)
            SC_SHL:  return (amt >= 8) ? 8'h00 : (d << amt);
            SC_SHR:  return (amt >= 8) ? 8'h00 : (d >> amt);
            SC_ROR:  return dd[7:0];
            default: return d;
        endcase
    endfunction

    function automatic int exp_passes(input logic [1:0] sc, input int amt);
`ifdef SHIFT_SEQ_BYPASS_EN
        if (sc == SC_NONE || amt == 0) return 0;
`endif
        if (sc == SC_NONE || amt == 0) return 1;
        return (amt + PM - 1) / PM;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One datapath pass, as the barrel register would apply it.
    function automatic logic [7:0] dp_pass(input logic [7:0] d, input logic [1:0] sc,
                                           input logic [2:0] a);
        logic [15:0] dd;
        dd = {d, d} >> a;
        case (sc)
            SC_SHL:  return d << a;
            SC_SHR:  return d >> a;
            SC_ROR:  return dd[7:0];
            default: return d;
        endcase
    endfunction

    logic [7:0] dl_q [BR_LAT];
    always @(posedge clk) begin
        if (!clear_n) begin
            for (int i = 0; i < BR_LAT; i++) dl_q[i] <= 8'h00;
        end else begin
            if (br_load) dl_q[0] <= dp_pass(br_data, br_sc, br_amt);
            for (int i = 1; i < BR_LAT; i++) dl_q[i] <= dl_q[i-1];
        end
    end
    assign br_r = dl_q[BR_LAT-1];

    // Monitor: samples on the falling edge, pushes expectations on accept, pops on response.
    initial begin
        exp_t       e;
        logic [7:0] d;
        logic [1:0] s;
        int         a;
        forever begin
            @(negedge clk);
            cyc++;
            if (!clear_n) begin
                sbq.delete();
                pass_cnt  = 0;
                first_cyc = -1;
                exp_ptr   = 0;
                hs_seen   = 2'b00;
            end else begin
                if (|req_ready) chk("grant_onehot", $countones(req_ready), 1);
                if (rsp_valid && (|req_valid)) chk("no_grant_in_done", req_ready, 0);
                if (!br_load) begin
                    chk("br_idle_zero", {br_data, br_sc, br_amt}, 0);
                end else if (sbq.size() == 0) begin
                    chk("br_load_no_job", br_load, 0);
                end else begin
                    chk("br_amt", br_amt, imin(cur_rem, PM));
                    chk("br_sc", br_sc, sbq[0].sc);
                    if (pass_cnt == 0) chk("br_data_first", br_data, sbq[0].opnd);
                    cur_rem -= int'(br_amt);
                    pass_cnt++;
                end
                if (rsp_valid) begin
                    if (sbq.size() == 0) begin
                        chk("rsp_no_job", rsp_valid, 0);
                    end else begin
                        if (first_cyc < 0) begin
                            first_cyc = cyc;
                            chk("latency", cyc - sbq[0].acc_cyc, sbq[0].lat);
                        end
                        if (rsp_ready) begin
                            chk("rsp_id", rsp_id, sbq[0].id);
                            chk("rsp_data", rsp_data, sbq[0].res);
                            chk("pass_count", pass_cnt, sbq[0].passes);
                            chk("amt_left", cur_rem, 0);
                            void'(sbq.pop_front());
                            pass_cnt  = 0;
                            first_cyc = -1;
                        end
                    end
                end
                hs_seen = req_valid & req_ready;
                for (int r = 0; r < 2; r++) begin
                    if (hs_seen[r]) begin
                        if (req_valid == 2'b11) chk("rr_winner", r, exp_ptr);
                        chk("one_in_flight", sbq.size(), 0);
                        d = (r == 1) ? db : da;
                        s = (r == 1) ? sbc : sa;
                        a = (r == 1) ? int'(ab) : int'(aa);
                        e.id      = (r == 1);
                        e.opnd    = d;
                        e.sc      = s;
                        e.res     = ref_result(d, s, a);
                        e.passes  = exp_passes(s, a);
                        e.lat     = (e.passes == 0) ? 1 : e.passes * (1 + BR_LAT) + 1;
                        e.acc_cyc = cyc;
                        sbq.push_back(e);
                        cur_rem   = (s == SC_NONE) ? 0 : a;
                        pass_cnt  = 0;
                        first_cyc = -1;
                        exp_ptr   = 1 - r;
                    end
                end
            end
        end
    end

    task automatic add_job(input int r, input int d, input int sc, input int amt);
        job_t j;
        j.d   = 8'(d);
        j.sc  = 2'(sc);
        j.amt = 5'(amt);
        if (r == 0) qa.push_back(j);
        else qb.push_back(j);
    endtask

    task automatic step();
        job_t j;
        @(posedge clk);
        #1;
        if (va && hs_seen[0]) va = 1'b0;
        if (vb && hs_seen[1]) vb = 1'b0;
        if (!va && qa.size() != 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
            j = qa.pop_front();
            da = j.d; sa = j.sc; aa = j.amt; va = 1'b1;
        end
        if (!vb && qb.size() != 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
            j = qb.pop_front();
            db = j.d; sbc = j.sc; ab = j.amt; vb = 1'b1;
        end
        case (ready_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((qa.size() != 0 || qb.size() != 0 || va || vb || sbq.size() != 0) && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: still busy after %0d cycles, required idle", k);
        end
    endtask

    initial begin
        int k;
        clear_n = 1'b0;
        va = 1'b1; vb = 1'b1;
        da = 8'hA5; db = 8'h3C;
        sa = SC_SHL; sbc = SC_SHL;
        aa = 5'd5; ab = 5'd5;
        rsp_ready = 1'b0;

        // Reset held for two clocks with both requesters asserting valid.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("reset_req_ready", req_ready, 0);
            chk("reset_br", {br_load, br_data, br_sc, br_amt}, 0);
            chk("reset_rsp", {rsp_valid, rsp_id, rsp_data}, 0);
        end
        va = 1'b0; vb = 1'b0;
        clear_n = 1'b1;

        add_job(0, 8'h81, SC_ROR, 3);
        wait_idle(100);
        add_job(1, 8'hFF, SC_SHL, 10);
        wait_idle(100);

        // Contention with the response held off for five cycles.
        ready_mode = 1;
        for (int i = 0; i < 2; i++) begin
            add_job(0, $urandom_range(0, 255), $urandom_range(1, 3), $urandom_range(1, 31));
            add_job(1, $urandom_range(0, 255), $urandom_range(1, 3), $urandom_range(1, 31));
        end
        k = 0;
        while (!rsp_valid && k < 100) begin
            step();
            k++;
        end
        if (!rsp_valid) chk("contention_rsp_timeout", rsp_valid, 1);
        repeat (5) step();
        ready_mode = 0;
        wait_idle(400);

        add_job(0, 8'h5A, SC_SHR, 0);
        wait_idle(100);
        add_job(1, 8'hC3, SC_NONE, 17);
        wait_idle(100);
        add_job(0, 8'h96, SC_ROR, 8);
        wait_idle(100);
        add_job(1, 8'h96, SC_SHR, 31);
        wait_idle(100);

        // Reset during the wait of the second pass of a long job from A.
        add_job(0, 8'hB7, SC_ROR, 20);
        k = 0;
        while (pass_cnt < 2 && k < 100) begin
            step();
            k++;
        end
        if (pass_cnt < 2) chk("mid_reset_pass2_timeout", pass_cnt, 2);
        clear_n = 1'b0;
        step();
        clear_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rsp_after_reset", rsp_valid, 0);
        end
        add_job(0, 8'h12, SC_SHL, 1);
        add_job(1, 8'h34, SC_SHR, 1);
        step();
        #2;
        chk("post_reset_grant", req_ready, 2'b01);
        wait_idle(200);

        // Randomised traffic with gaps and a stalling consumer.
        gaps = 1'b1;
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            add_job($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 3),
                    $urandom_range(0, 31));
        end
        wait_idle(5000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
